// File: rtl/encap_out_reader.sv
// encap_out_reader
//   Drains the encapsulation results of encap_seq_gen (ciphertext C0,
//   confirmation C1, session key K) once it signals done, and emits them as a
//   single ordered 32-bit valid/ready stream: C0[0..C0_WORDS-1], C1[0..7],
//   K[0..7].
//
//   Reads are issued one per cycle while a credit is free.
//   Occupancy of a 2-entry output FIFO plus reads still in flight never
//   exceeds 2, so a stalled sink can never overflow the FIFO. The credit test
//   subtracts a pop happening in the same cycle, which lets a continuously
//   ready sink receive one word per cycle with no bubbles.
//
//   Optional build macro ENCAP_OUT_HDR_EN: prepends the header word
//   {8'hEC, 8'(parameter_set), 16'(TOTAL_WORDS)} before C0[0]. It occupies
//   the first issue slot, so the first stream word still appears two cycles
//   after the start edge.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   start              one-cycle pulse from encap_seq_gen.done
//   rd_C0/C0_addr/C0_out  C0 read port (1-cycle read latency)
//   rd_C1/C1_addr/C1_out  C1 read port (1-cycle read latency)
//   rd_K/K_addr/K_out     K read port (1-cycle read latency)
//   dout, dout_valid, dout_ready, dout_last   output stream
//   busy               high from the accepted start until done
//   done               one-cycle pulse after the final handshake
module encap_out_reader #(
  parameter int parameter_set = 1,
  parameter int m             = (parameter_set == 1) ? 12 : 13,
  parameter int t             = (parameter_set == 1) ? 64 :
                                (parameter_set == 2) ? 96 :
                                (parameter_set == 4) ? 119 : 128,
  parameter int l             = m * t,
  parameter int C0_WORDS      = (l + 31) / 32,
  parameter int TOTAL_WORDS   = C0_WORDS + 16,
  localparam int C0_AW        = (C0_WORDS > 1) ? $clog2(C0_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic [31:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_C0 = 3'd1,
    RD_C1 = 3'd2,
    RD_K  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Source of a read in flight; selects the capture mux one cycle later.
  typedef enum logic [1:0] {
    SRC_C0  = 2'd0,
    SRC_C1  = 2'd1,
    SRC_K   = 2'd2,
    SRC_HDR = 2'd3
  } src_t;

`ifdef ENCAP_OUT_HDR_EN
  localparam logic [31:0] HDR_WORD = {8'hEC, 8'(parameter_set), 16'(TOTAL_WORDS)};
`endif

  state_t             state_q, state_d;
  logic [C0_AW-1:0]   c0_addr_q, c0_addr_d;
  logic [2:0]         c1_addr_q, c1_addr_d;
  logic [2:0]         k_addr_q, k_addr_d;
  logic               done_q, done_d;
  logic               hdr_pend_q, hdr_pend_d;

  // In-flight read (issued last cycle, data present on *_out this cycle).
  logic               pend_q;
  src_t               pend_src_q;
  logic               pend_last_q;

  // Issue decision for this cycle.
  logic               issue;
  src_t               issue_src;
  logic               issue_last;

  // 2-entry output FIFO.
  logic [31:0]        fifo_data_q [2];
  logic               fifo_last_q [2];
  logic               wr_ptr_q, rd_ptr_q;
  logic [1:0]         occ_q;

  logic               pop;
  logic [2:0]         load;
  logic               credit_ok;
  logic [31:0]        cap_data;

  assign pop       = (occ_q != 2'd0) && dout_ready;
  // Occupancy after this cycle's pop plus the read still in flight.
  assign load      = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
  assign credit_ok = (load < 3'd2);

  always_comb begin
    cap_data = C0_out;
    case (pend_src_q)
      SRC_C0:  cap_data = C0_out;
      SRC_C1:  cap_data = C1_out;
      SRC_K:   cap_data = K_out;
`ifdef ENCAP_OUT_HDR_EN
      SRC_HDR: cap_data = HDR_WORD;
`endif
      default: cap_data = C0_out;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    c0_addr_d  = c0_addr_q;
    c1_addr_d  = c1_addr_q;
    k_addr_d   = k_addr_q;
    done_d     = 1'b0;
    hdr_pend_d = hdr_pend_q;
    issue      = 1'b0;
    issue_src  = SRC_C0;
    issue_last = 1'b0;
    rd_C0      = 1'b0;
    rd_C1      = 1'b0;
    rd_K       = 1'b0;

    case (state_q)
      IDLE: begin
        // A start coinciding with the done pulse is ignored.
        if (start && !done_q) begin
          state_d    = RD_C0;
          c0_addr_d  = '0;
          hdr_pend_d = 1'b1;
        end
      end

      RD_C0: begin
        if (credit_ok) begin
          issue = 1'b1;
`ifdef ENCAP_OUT_HDR_EN
          if (hdr_pend_q) begin
            // Header takes the first slot; no memory read is needed.
            issue_src  = SRC_HDR;
            hdr_pend_d = 1'b0;
          end else
`endif
          begin
            rd_C0     = 1'b1;
            issue_src = SRC_C0;
            if (c0_addr_q == C0_AW'(C0_WORDS - 1)) begin
              state_d   = RD_C1;
              c1_addr_d = 3'd0;
            end else begin
              c0_addr_d = c0_addr_q + C0_AW'(1);
            end
          end
        end
      end

      RD_C1: begin
        if (credit_ok) begin
          rd_C1     = 1'b1;
          issue     = 1'b1;
          issue_src = SRC_C1;
          if (c1_addr_q == 3'd7) begin
            state_d  = RD_K;
            k_addr_d = 3'd0;
          end else begin
            c1_addr_d = c1_addr_q + 3'd1;
          end
        end
      end

      RD_K: begin
        if (credit_ok) begin
          rd_K      = 1'b1;
          issue     = 1'b1;
          issue_src = SRC_K;
          if (k_addr_q == 3'd7) begin
            state_d    = DRAIN;
            issue_last = 1'b1;
          end else begin
            k_addr_d = k_addr_q + 3'd1;
          end
        end
      end

      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      c0_addr_q      <= '0;
      c1_addr_q      <= 3'd0;
      k_addr_q       <= 3'd0;
      done_q         <= 1'b0;
      hdr_pend_q     <= 1'b0;
      pend_q         <= 1'b0;
      pend_src_q     <= SRC_C0;
      pend_last_q    <= 1'b0;
      fifo_data_q[0] <= 32'd0;
      fifo_data_q[1] <= 32'd0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
    end else begin
      state_q     <= state_d;
      c0_addr_q   <= c0_addr_d;
      c1_addr_q   <= c1_addr_d;
      k_addr_q    <= k_addr_d;
      done_q      <= done_d;
      hdr_pend_q  <= hdr_pend_d;
      pend_q      <= issue;
      pend_src_q  <= issue_src;
      pend_last_q <= issue_last;
      if (pend_q) begin
        fifo_data_q[wr_ptr_q] <= cap_data;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, pend_q} - {1'b0, pop};
    end
  end

  assign C0_addr    = c0_addr_q;
  assign C1_addr    = c1_addr_q;
  assign K_addr     = k_addr_q;
  assign dout       = fifo_data_q[rd_ptr_q];
  assign dout_valid = (occ_q != 2'd0);
  assign dout_last  = dout_valid && fifo_last_q[rd_ptr_q];
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_encap_out_reader.sv
module tb_encap_out_reader;

`ifdef ENCAP_OUT_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int N_A = 40 + HDR;
  localparam int N_B = 65 + HDR;

  logic        clk;
  logic        rst;

  // Instance A: parameter set 1
  logic        start_a, rd_c0_a, rd_c1_a, rd_k_a;
  logic [4:0]  c0_addr_a;
  logic [2:0]  c1_addr_a, k_addr_a;
  logic [31:0] c0_out_a, c1_out_a, k_out_a, dout_a;
  logic        dout_valid_a, ready_a, dout_last_a, busy_a, done_a;

  // Instance B: parameter set 4
  logic        start_b, rd_c0_b, rd_c1_b, rd_k_b;
  logic [5:0]  c0_addr_b;
  logic [2:0]  c1_addr_b, k_addr_b;
  logic [31:0] c0_out_b, c1_out_b, k_out_b, dout_b;
  logic        dout_valid_b, ready_b, dout_last_b, busy_b, done_b;

  int n_vec;
  int n_bad;

  encap_out_reader #(.parameter_set(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .rd_C0(rd_c0_a), .C0_addr(c0_addr_a), .C0_out(c0_out_a),
    .rd_C1(rd_c1_a), .C1_addr(c1_addr_a), .C1_out(c1_out_a),
    .rd_K(rd_k_a), .K_addr(k_addr_a), .K_out(k_out_a),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(ready_a),
    .dout_last(dout_last_a), .busy(busy_a), .done(done_a)
  );

  encap_out_reader #(.parameter_set(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .rd_C0(rd_c0_b), .C0_addr(c0_addr_b), .C0_out(c0_out_b),
    .rd_C1(rd_c1_b), .C1_addr(c1_addr_b), .C1_out(c1_out_b),
    .rd_K(rd_k_b), .K_addr(k_addr_b), .K_out(k_out_b),
    .dout(dout_b), .dout_valid(dout_valid_b), .dout_ready(ready_b),
    .dout_last(dout_last_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Preloaded result memories with 1-cycle registered read.
  always @(posedge clk) begin
    if (rd_c0_a) c0_out_a <= 32'hC000_0000 + 32'(c0_addr_a);
    if (rd_c1_a) c1_out_a <= 32'hC100_0000 + 32'(c1_addr_a);
    if (rd_k_a)  k_out_a  <= 32'h4B00_0000 + 32'(k_addr_a);
    if (rd_c0_b) c0_out_b <= 32'hC000_0000 + 32'(c0_addr_b);
    if (rd_c1_b) c1_out_b <= 32'hC100_0000 + 32'(c1_addr_b);
    if (rd_k_b)  k_out_b  <= 32'h4B00_0000 + 32'(k_addr_b);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int set, input int i);
    int c0w;
    int j;
    c0w = (set == 1) ? 24 : 49;
    j   = i - HDR;
    if (HDR == 1 && i == 0) return {8'hEC, 8'(set), 16'(c0w + 16)};
    if (j < c0w)            return 32'hC000_0000 + 32'(j);
    if (j < c0w + 8)        return 32'hC100_0000 + 32'(j - c0w);
    return 32'h4B00_0000 + 32'(j - c0w - 8);
  endfunction

  // pat 0: ready held high; pat 1: ready 1,0,0,1 repeating.
  // restart_at >= 0: pulse start at that word and again in the done cycle.
  // rst_at >= 0: assert reset at that word and abandon the stream.
  task automatic run_a(input int pat, input int restart_at, input int rst_at);
    int idx, e_last, dones, post, issued, accepted, max_out;
    bit fin, hold_v, hold_l, multi_rd, restarted;
    logic [31:0] hold_d;
    idx = 0; e_last = -1; dones = 0; post = 0; issued = 0; accepted = 0; max_out = 0;
    fin = 0; hold_v = 0; hold_l = 0; hold_d = 32'd0; multi_rd = 0; restarted = 0;
    start_a = 1'b1;
    @(posedge clk);  // start edge E0
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      ready_a = (pat == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      #1;
      if (c == 0) begin
        check_vec("a_rd_c0_first", 32'(rd_c0_a), 32'(1 - HDR));
        check_vec("a_c0_addr_first", 32'(c0_addr_a), 32'd0);
      end
      if (hold_v) begin
        check_vec("a_stall_dout", dout_a, hold_d);
        check_vec("a_stall_last", 32'(dout_last_a), 32'(hold_l));
      end
      if ((32'(rd_c0_a) + 32'(rd_c1_a) + 32'(rd_k_a)) > 32'd1) multi_rd = 1;
      if (rd_c0_a || rd_c1_a || rd_k_a) issued++;
      hold_v = 0;
      if (dout_valid_a) begin
        if (ready_a) begin
          $display("a word %0d = %h last=%0b", idx, dout_a, dout_last_a);
          check_vec("a_word", dout_a, exp_word(1, idx));
          check_vec("a_last", 32'(dout_last_a), 32'(idx == N_A - 1));
          if (dout_last_a) e_last = c + 1;
          idx++;
          accepted++;
        end else begin
          hold_v = 1;
          hold_d = dout_a;
          hold_l = dout_last_a;
        end
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (rst_at >= 0 && idx == rst_at) begin
        rst = 1'b1;
        #1;
        check_vec("rst_dout", dout_a, 32'd0);
        check_vec("rst_valid", 32'(dout_valid_a), 32'd0);
        check_vec("rst_last", 32'(dout_last_a), 32'd0);
        check_vec("rst_busy", 32'(busy_a), 32'd0);
        check_vec("rst_rd_c0", 32'(rd_c0_a), 32'd0);
        check_vec("rst_c0_addr", 32'(c0_addr_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ready_a = 1'b1;
        return;
      end
      if (done_a) begin
        dones++;
        if (dones == 1) begin
          check_vec("a_done_cycle", c, e_last);
          check_vec("a_busy_at_done", 32'(busy_a), 32'd0);
          if (restart_at >= 0) start_a = 1'b1;  // must be ignored
        end
      end
      if (dones > 0) post++;
      if (post == 6) fin = 1;
      if (restart_at >= 0 && !restarted && idx == restart_at) begin
        start_a = 1'b1;
        restarted = 1;
      end
    end
    check_vec("a_word_count", idx, N_A);
    check_vec("a_done_pulses", dones, 1);
    if (pat == 0) check_vec("a_latency", e_last, N_A + 2);
    check_vec("a_max_outstanding", 32'(max_out <= 2), 32'd1);
    check_vec("a_one_rd", 32'(multi_rd), 32'd0);
    check_vec("a_idle_busy", 32'(busy_a), 32'd0);
    check_vec("a_idle_valid", 32'(dout_valid_a), 32'd0);
  endtask

  task automatic run_b();
    int idx, max_addr;
    bit seen_c1, fin;
    idx = 0; max_addr = 0; seen_c1 = 0; fin = 0;
    start_b = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      #1;
      if (rd_c0_b && int'(c0_addr_b) > max_addr) max_addr = int'(c0_addr_b);
      if (rd_c1_b && !seen_c1) begin
        seen_c1 = 1;
        check_vec("b_c0_addr_max", max_addr, 48);
        check_vec("b_c1_first_addr", 32'(c1_addr_b), 32'd0);
      end
      if (dout_valid_b) begin
        $display("b word %0d = %h last=%0b", idx, dout_b, dout_last_b);
        check_vec("b_word", dout_b, exp_word(4, idx));
        check_vec("b_last", 32'(dout_last_b), 32'(idx == N_B - 1));
        idx++;
      end
      if (done_b) fin = 1;
    end
    check_vec("b_word_count", idx, N_B);
    check_vec("b_done_seen", 32'(fin), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("reset_dout", dout_a, 32'd0);
    check_vec("reset_valid", 32'(dout_valid_a), 32'd0);
    check_vec("reset_busy", 32'(busy_a), 32'd0);
    check_vec("reset_done", 32'(done_a), 32'd0);
    check_vec("reset_rd", 32'(rd_c0_a | rd_c1_a | rd_k_a), 32'd0);
    check_vec("reset_addrs", 32'({c0_addr_a, c1_addr_a, k_addr_a}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_a(0, -1, -1);  // full-rate stream
    run_a(1, -1, -1);  // backpressure 1,0,0,1
    run_a(0, 10, -1);  // start re-pulsed mid-stream and on done
    run_a(0, -1, 20);  // reset mid-stream
    run_a(0, -1, -1);  // clean stream after reset
    run_b();           // parameter set 4
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
